aoi_eval_seq: RTL and testbench



---
 rtl/aoi_eval_seq.sv | 90 +++++++++
 tb/tb_aoi_eval_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aoi_eval_seq.sv
// Sequential AND-OR-INVERT: y = ~|(a[i] & b[i]) over N_PAIRS W-bit pairs, one pair per clock.
// start accepted only in IDLE; busy covers EVAL and DONE; done is a one-cycle result strobe.
module aoi_eval_seq #(
  parameter int N_PAIRS    = 3,
  parameter int W          = 1,
  parameter int EARLY_EXIT = 0,
  parameter int CW         = $clog2(N_PAIRS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_PAIRS*W-1:0] a_in,
  input  logic [N_PAIRS*W-1:0] b_in,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         y,
  output logic [CW-1:0]        cycles
);

  localparam int IW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [N_PAIRS*W-1:0] a_q;
  logic [N_PAIRS*W-1:0] b_q;
  logic [W-1:0]         acc;
  logic [IW-1:0]        idx;

  logic [W-1:0] a_arr [N_PAIRS];
  logic [W-1:0] b_arr [N_PAIRS];

  for (genvar i = 0; i < N_PAIRS; i++) begin : g_split
    assign a_arr[i] = a_q[i*W +: W];
    assign b_arr[i] = b_q[i*W +: W];
  end

  logic [W-1:0] acc_next;
  logic         last_pair;
  logic         finish;

  always_comb begin
    acc_next  = acc | (a_arr[idx] & b_arr[idx]);
    last_pair = (idx == IW'(N_PAIRS - 1));
    // Once every bit is set the inverted result can only be zero, so stop early if allowed.
    finish    = last_pair || ((EARLY_EXIT != 0) && (&acc_next));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      idx    <= '0;
      y      <= {W{1'b1}};
      cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc   <= '0;
            idx   <= '0;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          acc <= acc_next;
          if (finish) begin
            y      <= ~acc_next;
            cycles <= CW'(idx) + CW'(1);
            state  <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_EVAL) || (state == S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_aoi_eval_seq.sv
// Scoreboard bench: drivers push expected {y, cycles, done cycle}; per-instance monitors pop on done.
module tb_aoi_eval_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] y;
    int         cyc_cnt;
    int         at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // u0: N=3 W=1 no early exit; u1: N=3 W=1 early exit; u2: N=4 W=4 early exit
  logic        rst0, rst1, rst2;
  logic        start0, start1, start2;
  logic [2:0]  a0, b0, a1, b1;
  logic [15:0] a2, b2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic        y0, y1;
  logic [3:0]  y2;
  logic [1:0]  cycles0, cycles1;
  logic [2:0]  cycles2;

  aoi_eval_seq #(.N_PAIRS(3), .W(1), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .a_in(a0), .b_in(b0),
    .busy(busy0), .done(done0), .y(y0), .cycles(cycles0));

  aoi_eval_seq #(.N_PAIRS(3), .W(1), .EARLY_EXIT(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .y(y1), .cycles(cycles1));

  aoi_eval_seq #(.N_PAIRS(4), .W(4), .EARLY_EXIT(1)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .a_in(a2), .b_in(b2),
    .busy(busy2), .done(done2), .y(y2), .cycles(cycles2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int id);
    if (id == 0) return q0.size();
    if (id == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic exp_t qpop(input int id);
    if (id == 0) return q0.pop_front();
    if (id == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  task automatic qpush(input int id, input exp_t e);
    if (id == 0) q0.push_back(e);
    else if (id == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  logic prev_done [3] = '{1'b0, 1'b0, 1'b0};

  task automatic observe(input int id, input logic d, input logic [3:0] yv, input int cv);
    exp_t e;
    string tag;
    tag = $sformatf("u%0d", id);
    if (d) begin
      chk({tag, "_done_gap"}, 32'(prev_done[id]), 32'd0);
      if (qsize(id) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected_done: got done at cycle %0d expected none", tag, cyc);
      end else begin
        e = qpop(id);
        chk({tag, "_y"}, 32'(yv), 32'(e.y));
        chk({tag, "_cycles"}, 32'(cv), 32'(e.cyc_cnt));
        chk({tag, "_latency"}, 32'(cyc), 32'(e.at));
      end
    end
    prev_done[id] = d;
  endtask

  always @(negedge clk) begin
    if (!rst0) observe(0, done0, {3'b0, y0}, int'(cycles0));
    if (!rst1) observe(1, done1, {3'b0, y1}, int'(cycles1));
    if (!rst2) observe(2, done2, y2, int'(cycles2));
  end

  // Pulses start for one cycle; done expected at the negedge lat cycles after the start edge.
  task automatic launch(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] ey, input int ec, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    case (id)
      0: begin start0 = 1'b1; a0 = a[2:0]; b0 = b[2:0]; end
      1: begin start1 = 1'b1; a1 = a[2:0]; b1 = b[2:0]; end
      default: begin start2 = 1'b1; a2 = a; b2 = b; end
    endcase
    e.y = ey;
    e.cyc_cnt = ec;
    e.at = cyc + 1 + lat;
    if (push) qpush(id, e);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while (qsize(id) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (qsize(id) != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL u%0d_timeout: got %0d pending results expected 0", id, qsize(id));
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int c;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'({busy0, busy1, busy2}), 32'd0);
    chk("rst_done", 32'({done0, done1, done2}), 32'd0);
    chk("rst_y", 32'({y0, y1, y2}), 32'h3f);
    chk("rst_cycles", 32'({cycles0, cycles1, cycles2}), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    repeat (2) @(negedge clk);

    // A=1,B=0,C=0,D=1: no pair true -> y=1; stray start pulses in EVAL and DONE are ignored
    launch(0, 16'h1, 16'h2, 4'h1, 3, 3, 1'b1);
    chk("u0_busy_eval", 32'(busy0), 32'd1);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    drain(0);

    launch(0, 16'h1, 16'h1, 4'h0, 3, 3, 1'b1);
    drain(0);

    // C&D true; inputs go all-ones after start but latched operands decide
    launch(0, 16'h2, 16'h2, 4'h0, 3, 3, 1'b1);
    a0 = 3'b111; b0 = 3'b111;
    drain(0);

    // Reset in the second EVAL cycle discards the operation
    launch(0, 16'h1, 16'h1, 4'h0, 3, 3, 1'b0);
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk);
    chk("u0_midrst_busy", 32'(busy0), 32'd0);
    chk("u0_midrst_done", 32'(done0), 32'd0);
    chk("u0_midrst_y", 32'(y0), 32'd1);
    chk("u0_midrst_cycles", 32'(cycles0), 32'd0);
    rst0 = 1'b0;
    repeat (8) @(negedge clk);

    // start held high: accepted every N_PAIRS+2 = 5 cycles
    @(negedge clk);
    c = cyc;
    start0 = 1'b1; a0 = 3'b000; b0 = 3'b000;
    qpush(0, '{y: 4'h1, cyc_cnt: 3, at: c + 4});
    qpush(0, '{y: 4'h1, cyc_cnt: 3, at: c + 9});
    qpush(0, '{y: 4'h1, cyc_cnt: 3, at: c + 14});
    while (cyc < c + 13) @(negedge clk);
    start0 = 1'b0;
    drain(0);

    // Early exit on the N=3, W=1 instance
    launch(1, 16'h1, 16'h1, 4'h0, 1, 1, 1'b1);
    drain(1);
    launch(1, 16'h2, 16'h2, 4'h0, 2, 2, 1'b1);
    drain(1);
    launch(1, 16'h5, 16'h2, 4'h1, 3, 3, 1'b1);
    drain(1);

    // N=4, W=4: acc 1000, 1011, 1011, 1111 -> y=0000 after all four pairs
    launch(2, 16'hF03C, 16'hFF7A, 4'h0, 4, 4, 1'b1);
    drain(2);
    launch(2, 16'h000F, 16'h000F, 4'h0, 1, 1, 1'b1);
    drain(2);
    // acc ends at 0111 -> y=1000
    launch(2, 16'h1234, 16'h00FF, 4'h8, 4, 4, 1'b1);
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
